fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Read-side output stage placed directly downstream of the async FIFO, in the read clock domain.
- Consumes the FIFO's first-word-fall-through read port (data/empty/rinc) and presents a registered valid/ready stream to downstream logic.
- Holds a 2-entry buffer, so the FIFO pop request never depends combinationally on downstream ready.
- Also provides transfer and stall statistics counters.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- CNT_W, 16, width of the statistics counters.

Ports:
- i_clk  in  1  read-domain clock (same clock as the FIFO read side).
- i_rst  in  1  reset; one clock, reset is synchronous and active-high.
- i_fifo_empty  in  1  FIFO empty flag.
- i_fifo_data  in  WIDTH  FIFO head word; valid whenever i_fifo_empty=0.
- o_fifo_rinc  out  1  FIFO pop; the head word is consumed at this clock edge.
- i_flush  in  1  synchronous discard of buffered words.
- o_valid  out  1  output word valid.
- o_data  out  WIDTH  output word (registered).
- i_ready  in  1  downstream accepts o_data when o_valid=1.
- o_pop_cnt  out  CNT_W  count of accepted output transfers; wraps modulo 2^CNT_W.
- o_stall_cnt  out  CNT_W  count of cycles with o_valid=1 and i_ready=0; saturates at all-ones.

Behaviour:
- State: occupancy cnt in {EMPTY=0, ONE=1, TWO=2}; registers head and skid.
- o_valid = (cnt!=0). o_data = head.
- push = o_fifo_rinc = !i_rst && !i_flush && !i_fifo_empty && (cnt!=TWO).
  - Function of registered state and FIFO flag only; no i_ready term.
- pop = o_valid && i_ready.
- Transitions (no reset, no flush):
  - EMPTY: push → ONE, head<=i_fifo_data.
  - ONE, push&pop: stay ONE, head<=i_fifo_data.
  - ONE, push only: → TWO, skid<=i_fifo_data.
  - ONE, pop only: → EMPTY.
  - TWO: push impossible; pop → ONE, head<=skid.
- Latency: word present at the FIFO head with empty=0 at edge k appears on o_data/o_valid after edge k (1 cycle).
- Throughput: 1 word/cycle sustained when the FIFO is non-empty and i_ready=1 (steady state ONE).
- Ordering: strict FIFO order; skid is always older than any new FIFO word.
- Downstream backpressure: at most one extra word is pulled after i_ready falls (ONE→TWO); then rinc stays 0 until a pop.
- Never asserts o_fifo_rinc while i_fifo_empty=1.
- i_flush=1:
  - Next state is EMPTY; head and skid contents are don't-care.
  - o_fifo_rinc=0 in that cycle.
  - A pop occurring in the flush cycle still counts in o_pop_cnt.
- Counters:
  - o_pop_cnt += 1 on each pop, wraps at max.
  - o_stall_cnt += 1 on each cycle with o_valid && !i_ready, holds at 2^CNT_W-1.
  - Both are unaffected by i_flush.
- Reset (i_rst=1 at the edge):
  - cnt=EMPTY, o_valid=0, o_data=0, skid=0, o_pop_cnt=0, o_stall_cnt=0.
  - o_fifo_rinc=0 combinationally during reset.
  - Mid-operation reset discards buffered words; words still in the FIFO are not popped and remain.
- o_valid/o_data must hold stable while o_valid=1 and i_ready=0.

Decomposition:
- Package fifo_rd_pkg holds:
  - Occupancy encodings EMPTY/ONE/TWO as 2-bit localparams.
  - OCC_W=2 constant.
- One natural sub-module: sat_counter (parameterized width, inc, sync clear, saturate-or-wrap select), instantiated twice for o_pop_cnt and o_stall_cnt.

Test Plan:
- Reset, FIFO empty, i_ready=1 → o_valid=0, o_fifo_rinc=0, both counters 0; no rinc for 10 cycles.
- Stream 0x01..0x10 with i_ready=1 throughout:
  - o_fifo_rinc high for 16 consecutive cycles.
  - o_data 0x01..0x10 on consecutive cycles, 1 cycle after each pop.
  - o_pop_cnt=16, o_stall_cnt=0.
- Backpressure:
  - FIFO holds 0xA0..0xA7; drop i_ready after 0xA1 is accepted.
  - Exactly one further rinc (cnt=2), o_data holds 0xA2 stable.
  - Raise i_ready after 5 cycles → 0xA2, 0xA3, … in order, none lost or duplicated; o_stall_cnt=5.
- Flush in state TWO → next cycle o_valid=0, o_fifo_rinc=0 during the flush cycle, the next FIFO word appears 1 cycle after flush deasserts.
- Reset asserted mid-stream with cnt=2 → o_valid=0 after the edge, counters 0, FIFO occupancy unchanged by the reset cycle.
- CNT_W=4, i_ready=0 with o_valid=1 for 20 cycles → o_stall_cnt stops at 15. Then 17 accepted transfers → o_pop_cnt wraps to 1.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared constants for the FIFO read-side output stage.
//
// The output stage holds at most two words, so its occupancy fits in a
// 2-bit code. Every file of the stage imports these encodings so that the
// buffer logic and anything observing it agree on one set of values.
package fifo_rd_pkg;

   localparam int OCC_W = 2;

   localparam logic [OCC_W-1:0] EMPTY = 2'd0;
   localparam logic [OCC_W-1:0] ONE   = 2'd1;
   localparam logic [OCC_W-1:0] TWO   = 2'd2;

endpackage

// File: rtl/fifo_rd_stream_sat_counter.sv
// Module sat_counter: a generic statistics counter.
//
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears the count
//   clr   - synchronous clear, same effect as rst but driven by logic
//   inc   - add one to the count at this clock edge
//   count - current count (registered)
//
// SATURATE=1 makes the counter stick at all-ones. SATURATE=0 lets it wrap
// back to zero after all-ones.
module sat_counter #(
   parameter int WIDTH    = 16,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count. The increment is suppressed only when saturating and
   // already at the top value; the wrapping variant simply overflows.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && !(SATURATE && (&count_q))) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side output stage for the async FIFO, in the read clock domain.
//
// Takes the FIFO's first-word-fall-through port and turns it into a
// registered valid/ready stream. A two-entry buffer (head + skid) means the
// FIFO pop never has to look at downstream ready in the same cycle.
//
// Ports:
//   i_clk, i_rst   - read clock, synchronous active-high reset
//   i_fifo_empty   - FIFO empty flag
//   i_fifo_data    - FIFO head word, valid while i_fifo_empty=0
//   o_fifo_rinc    - pops the FIFO head at this clock edge
//   i_flush        - discard everything buffered here
//   o_valid/o_data - output stream word (registered)
//   i_ready        - downstream accepts o_data when o_valid=1
//   o_pop_cnt      - accepted transfers, wrapping
//   o_stall_cnt    - cycles with o_valid=1 and i_ready=0, saturating
module fifo_rd_stream
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_fifo_empty,
   input  logic [WIDTH-1:0] i_fifo_data,
   output logic             o_fifo_rinc,
   input  logic             i_flush,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   input  logic             i_ready,
   output logic [CNT_W-1:0] o_pop_cnt,
   output logic [CNT_W-1:0] o_stall_cnt
);

   logic [OCC_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             push;
   logic             pop;
   logic             stall;

   // The pop request looks only at registered occupancy and the FIFO flag,
   // never at i_ready, so there is no combinational ready-to-rinc path.
   // With one free slot we can always absorb a new word even if downstream
   // stops accepting in the same cycle.
   always_comb begin
      push  = !i_rst && !i_flush && !i_fifo_empty && (cnt_q != TWO);
      pop   = (cnt_q != EMPTY) && i_ready;
      stall = (cnt_q != EMPTY) && !i_ready;
   end

   // Occupancy and data movement. The skid slot only fills when the head is
   // stuck, so it always holds an older word than the current FIFO head and
   // is moved into head before anything new is taken.
   always_comb begin
      cnt_d  = cnt_q;
      head_d = head_q;
      skid_d = skid_q;
      if (i_flush) begin
         cnt_d = EMPTY;
      end else begin
         case (cnt_q)
            EMPTY: begin
               if (push) begin
                  cnt_d  = ONE;
                  head_d = i_fifo_data;
               end
            end
            ONE: begin
               if (push && pop) begin
                  head_d = i_fifo_data;
               end else if (push) begin
                  cnt_d  = TWO;
                  skid_d = i_fifo_data;
               end else if (pop) begin
                  cnt_d = EMPTY;
               end
            end
            TWO: begin
               if (pop) begin
                  cnt_d  = ONE;
                  head_d = skid_q;
               end
            end
            default: begin
               cnt_d = EMPTY;
            end
         endcase
      end
   end

   // Buffer registers. Reset drops anything held here; words still in the
   // FIFO are untouched because push is forced low during reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q  <= EMPTY;
         head_q <= '0;
         skid_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
         skid_q <= skid_d;
      end
   end

   assign o_fifo_rinc = push;
   assign o_valid     = (cnt_q != EMPTY);
   assign o_data      = head_q;

   // Statistics run off the stream handshake only, so a flush does not
   // disturb them and a pop in the flush cycle is still counted.
   sat_counter #(
      .WIDTH   (CNT_W),
      .SATURATE(1'b0)
   ) u_pop_cnt (
      .clk  (i_clk),
      .rst  (i_rst),
      .clr  (1'b0),
      .inc  (pop),
      .count(o_pop_cnt)
   );

   sat_counter #(
      .WIDTH   (CNT_W),
      .SATURATE(1'b1)
   ) u_stall_cnt (
      .clk  (i_clk),
      .rst  (i_rst),
      .clr  (1'b0),
      .inc  (stall),
      .count(o_stall_cnt)
   );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream.
//
// A queue stands in for the async FIFO read port. Two DUT copies share all
// inputs: the default one (16-bit counters) and one with 4-bit counters so
// saturation and wrap can be reached quickly. Expected output words are
// queued when loaded into the FIFO and popped by a monitor on each accepted
// transfer. Inputs change 2 time units after the rising edge; the monitor
// samples on the falling edge.
module tb_fifo_rd_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fifo_empty = 1'b1;
   logic [7:0]  fifo_data = 8'h00;
   logic        flush = 1'b0;
   logic        ready = 1'b1;

   logic        rinc;
   logic        valid;
   logic [7:0]  data;
   logic [15:0] pop_cnt;
   logic [15:0] stall_cnt;

   logic        rinc4;
   logic        valid4;
   logic [7:0]  data4;
   logic [3:0]  pop4;
   logic [3:0]  stall4;

   logic [7:0]  fifoQ[$];
   logic [7:0]  expQ[$];
   logic        rincSeen = 1'b0;
   int          rincCount = 0;
   int          rincStreak = 0;
   int          rincMaxStreak = 0;
   int          popSeen = 0;
   int          checks = 0;
   int          errors = 0;

   fifo_rd_stream #(.WIDTH(8), .CNT_W(16)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_fifo_empty(fifo_empty),
      .i_fifo_data (fifo_data),
      .o_fifo_rinc (rinc),
      .i_flush     (flush),
      .o_valid     (valid),
      .o_data      (data),
      .i_ready     (ready),
      .o_pop_cnt   (pop_cnt),
      .o_stall_cnt (stall_cnt)
   );

   fifo_rd_stream #(.WIDTH(8), .CNT_W(4)) dut4 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_fifo_empty(fifo_empty),
      .i_fifo_data (fifo_data),
      .o_fifo_rinc (rinc4),
      .i_flush     (flush),
      .o_valid     (valid4),
      .o_data      (data4),
      .i_ready     (ready),
      .o_pop_cnt   (pop4),
      .o_stall_cnt (stall4)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic refreshFifo();
      fifo_empty = (fifoQ.size() == 0);
      fifo_data  = (fifoQ.size() != 0) ? fifoQ[0] : 8'h00;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic r, input logic f, input logic rdy);
      rst   = r;
      flush = f;
      ready = rdy;
   endtask

   task automatic pushWord(input logic [7:0] w);
      fifoQ.push_back(w);
      expQ.push_back(w);
      refreshFifo();
   endtask

   task automatic dropExpected(input int n);
      for (int i = 0; i < n; i++) begin
         if (expQ.size() != 0) expQ.delete(0);
      end
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while ((expQ.size() != 0 || valid) && n < bound) begin
         step();
         n++;
      end
      if (n >= bound) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain timeout pending=%0d required=0", expQ.size());
      end
   endtask

   // FIFO model: the head word leaves one unit after an edge at which the
   // DUT was requesting a pop.
   always begin
      @(posedge clk);
      #1;
      if (rincSeen) begin
         if (fifoQ.size() != 0) fifoQ.delete(0);
      end
      refreshFifo();
   end

   // Monitor: records the pop request for the FIFO model, checks that no
   // pop is requested from an empty FIFO, and scores every accepted word.
   always @(negedge clk) begin
      rincSeen = rinc;
      checkOutput("rinc while empty", {31'd0, (rinc | rinc4) & fifo_empty}, 32'd0);
      if (rinc) begin
         rincCount++;
         rincStreak++;
         if (rincStreak > rincMaxStreak) rincMaxStreak = rincStreak;
      end else begin
         rincStreak = 0;
      end
      if (!rst && valid === 1'b1 && ready) begin
         popSeen++;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected word actual=%0h required=none", data);
         end else begin
            checkOutput("stream data", {24'd0, data}, {24'd0, expQ[0]});
            checkOutput("dut4 data", {24'd0, data4}, {24'd0, expQ[0]});
            checkOutput("dut4 valid", {31'd0, valid4}, 32'd1);
            expQ.delete(0);
         end
      end
   end

   initial begin
      int rincStart;
      int popStart;

      // Reset with an empty FIFO: nothing valid, nothing requested.
      applyStimulus(1'b1, 1'b0, 1'b1);
      step();
      step();
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("reset valid", {31'd0, valid}, 32'd0);
      checkOutput("reset data", {24'd0, data}, 32'd0);
      checkOutput("reset pop_cnt", {16'd0, pop_cnt}, 32'd0);
      checkOutput("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
      rincStart = rincCount;
      repeat (10) step();
      checkOutput("idle rinc count", rincCount - rincStart, 32'd0);
      checkOutput("idle valid", {31'd0, valid}, 32'd0);

      // Stream 0x01..0x10 with ready held high.
      rincStart = rincCount;
      popStart  = popSeen;
      rincMaxStreak = 0;
      for (int i = 1; i <= 16; i++) pushWord(8'(i));
      repeat (17) step();
      checkOutput("stream rinc count", rincCount - rincStart, 32'd16);
      checkOutput("stream rinc streak", rincMaxStreak, 32'd16);
      checkOutput("stream pops in 17 cycles", popSeen - popStart, 32'd16);
      checkOutput("stream drained valid", {31'd0, valid}, 32'd0);
      checkOutput("stream pop_cnt", {16'd0, pop_cnt}, 32'd16);
      checkOutput("stream stall_cnt", {16'd0, stall_cnt}, 32'd0);

      // Backpressure: drop ready once 0xA1 has been accepted.
      for (int i = 0; i < 8; i++) pushWord(8'hA0 + 8'(i));
      repeat (3) step();
      applyStimulus(1'b0, 1'b0, 1'b0);
      rincStart = rincCount;
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("stall valid", {31'd0, valid}, 32'd1);
         checkOutput("stall data hold", {24'd0, data}, 32'hA2);
      end
      checkOutput("stall extra rinc", rincCount - rincStart, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      drain(30);
      checkOutput("backpressure stall_cnt", {16'd0, stall_cnt}, 32'd5);
      checkOutput("backpressure pop_cnt", {16'd0, pop_cnt}, 32'd24);

      // Flush while two words are held; the third word stays in the FIFO.
      applyStimulus(1'b0, 1'b0, 1'b0);
      pushWord(8'hB0);
      pushWord(8'hB1);
      pushWord(8'hB2);
      step();
      step();
      applyStimulus(1'b0, 1'b1, 1'b0);
      #1;
      checkOutput("flush rinc", {31'd0, rinc}, 32'd0);
      dropExpected(2);
      rincStart = rincCount;
      step();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("after flush valid", {31'd0, valid}, 32'd0);
      checkOutput("flush cycle rinc count", rincCount - rincStart, 32'd0);
      step();
      checkOutput("post flush valid", {31'd0, valid}, 32'd1);
      checkOutput("post flush data", {24'd0, data}, 32'hB2);
      applyStimulus(1'b0, 1'b0, 1'b1);
      drain(20);
      checkOutput("flush stall_cnt", {16'd0, stall_cnt}, 32'd7);
      checkOutput("flush pop_cnt", {16'd0, pop_cnt}, 32'd25);

      // Reset with two words held and two more waiting in the FIFO.
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) pushWord(8'hC0 + 8'(i));
      step();
      step();
      applyStimulus(1'b1, 1'b0, 1'b0);
      #1;
      checkOutput("reset rinc", {31'd0, rinc}, 32'd0);
      dropExpected(2);
      step();
      checkOutput("midreset valid", {31'd0, valid}, 32'd0);
      checkOutput("midreset pop_cnt", {16'd0, pop_cnt}, 32'd0);
      checkOutput("midreset stall_cnt", {16'd0, stall_cnt}, 32'd0);
      checkOutput("midreset pop4", {28'd0, pop4}, 32'd0);
      checkOutput("midreset stall4", {28'd0, stall4}, 32'd0);
      checkOutput("midreset fifo level", fifoQ.size(), 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b1);
      drain(20);
      checkOutput("after reset pop_cnt", {16'd0, pop_cnt}, 32'd2);

      // Counter limits: 20 stalled cycles, then 17 accepted words.
      applyStimulus(1'b1, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0);
      pushWord(8'h40);
      step();
      repeat (20) step();
      checkOutput("stall16 after 20", {16'd0, stall_cnt}, 32'd20);
      checkOutput("stall4 saturated", {28'd0, stall4}, 32'd15);
      applyStimulus(1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 16; i++) pushWord(8'h40 + 8'(i));
      drain(60);
      checkOutput("pop16 after 17", {16'd0, pop_cnt}, 32'd17);
      checkOutput("pop4 wrapped", {28'd0, pop4}, 32'd1);
      checkOutput("stall4 held", {28'd0, stall4}, 32'd15);
      checkOutput("stall16 held", {16'd0, stall_cnt}, 32'd20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
